uart_apb_tx_sched: RTL

Round-robin scheduler that shares one CoreUARTapb transmitter among up to four byte requesters. It acts as a single APB master on the UART's 5-bit register bus. After reset it writes the two baud/format control registers once. It then grants requesters in turn: it polls the status register for TXRDY and writes each granted byte to the TX data register.

---
 rtl/uart_apb_tx_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_apb_tx_sched.sv
// Round-robin byte scheduler feeding a CoreUARTapb transmitter over APB.
// Writes the two baud/format registers once after reset, then polls TXRDY before every TX write.
module uart_apb_tx_sched #(
    parameter int          NREQ         = 2,
    parameter logic [12:0] BAUD_VALUE   = 13'd1,
    parameter logic        BIT8         = 1'b1,
    parameter logic        PARITY_EN    = 1'b0,
    parameter logic        ODD_N_EVEN   = 1'b0,
    parameter logic [15:0] TX_COUNT_RST = 16'h0000
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [4:0]          PADDR,
    output logic [7:0]          PWDATA,
    input  logic [7:0]          PRDATA,
    input  logic                PREADY,
    output logic                cfg_done,
    output logic [1:0]          grant,
    output logic [15:0]         tx_count
);

    // state  | meaning
    // CFG1_S | setup write of control1 (baud low byte)
    // CFG1_A | access write of control1
    // CFG2_S | setup write of control2 (baud high bits, format)
    // CFG2_A | access write of control2
    // IDLE   | arbitrate, accept one byte
    // POLL_S | setup read of status
    // POLL_A | access read of status, retry until TXRDY
    // WR_S   | setup write of TX data
    // WR_A   | access write of TX data
    typedef enum logic [3:0] {
        CFG1_S, CFG1_A, CFG2_S, CFG2_A, IDLE, POLL_S, POLL_A, WR_S, WR_A
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_active;
    logic        r_cfg_done;
    logic [1:0]  r_grant;
    logic [1:0]  r_ptr;
    logic [7:0]  r_byte;
    logic [15:0] r_tx_count;

    logic [3:0]  w_valid4;
    logic [3:0]  w_ready4;
    logic        w_found;
    logic [1:0]  w_sel;
    logic [7:0]  w_sel_data;
    logic [1:0]  w_ptr_next;
    logic        w_unused_prdata;

    assign w_unused_prdata = &{1'b0, PRDATA[7:1]};

    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[1:0];
    endfunction

    always_comb begin
        w_valid4 = '0;
        for (int i = 0; i < NREQ; i++) w_valid4[i] = req_valid[i];
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_valid4[wrap_add(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_add(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == 2'(i)) w_sel_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_ready4 = '0;
        if (r_state == IDLE && w_found) w_ready4[w_sel] = 1'b1;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) req_ready[i] = w_ready4[i];
    end

    assign w_ptr_next = (int'(r_grant) >= NREQ - 1) ? 2'd0 : r_grant + 2'd1;

    // r_active keeps the bus quiet while reset is held, even though the state already sits in CFG1_S
    always_comb begin
        w_state_next = r_state;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 5'h00;
        PWDATA  = 8'h00;
        if (r_active) begin
            case (r_state)
                CFG1_S, CFG1_A: begin
                    PSEL    = 1'b1;
                    PENABLE = (r_state == CFG1_A);
                    PWRITE  = 1'b1;
                    PADDR   = 5'h08;
                    PWDATA  = BAUD_VALUE[7:0];
                    w_state_next = (r_state == CFG1_S) ? CFG1_A : (PREADY ? CFG2_S : CFG1_A);
                end
                CFG2_S, CFG2_A: begin
                    PSEL    = 1'b1;
                    PENABLE = (r_state == CFG2_A);
                    PWRITE  = 1'b1;
                    PADDR   = 5'h0C;
                    PWDATA  = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
                    w_state_next = (r_state == CFG2_S) ? CFG2_A : (PREADY ? IDLE : CFG2_A);
                end
                IDLE: begin
                    if (w_found) w_state_next = POLL_S;
                end
                POLL_S, POLL_A: begin
                    PSEL    = 1'b1;
                    PENABLE = (r_state == POLL_A);
                    PADDR   = 5'h10;
                    if (r_state == POLL_S) w_state_next = POLL_A;
                    else if (PREADY)       w_state_next = PRDATA[0] ? WR_S : POLL_S;
                end
                WR_S, WR_A: begin
                    PSEL    = 1'b1;
                    PENABLE = (r_state == WR_A);
                    PWRITE  = 1'b1;
                    PADDR   = 5'h00;
                    PWDATA  = r_byte;
                    w_state_next = (r_state == WR_S) ? WR_A : (PREADY ? IDLE : WR_A);
                end
                default: w_state_next = CFG1_S;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= CFG1_S;
            r_active   <= 1'b0;
            r_cfg_done <= 1'b0;
            r_grant    <= 2'd0;
            r_ptr      <= 2'd0;
            r_byte     <= 8'h00;
            r_tx_count <= TX_COUNT_RST;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_next;
            if (r_state == CFG2_A && PREADY) r_cfg_done <= 1'b1;
            if (r_state == IDLE && w_found) begin
                r_grant <= w_sel;
                r_byte  <= w_sel_data;
            end
            if (r_state == WR_A && PREADY) begin
                r_tx_count <= r_tx_count + 16'd1;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    assign cfg_done = r_cfg_done;
    assign grant    = r_grant;
    assign tx_count = r_tx_count;

endmodule
